// File: rtl/sprite_palette_encoder.sv
// Loads a sprite rectangle from a raster pixel stream, maps each RGB colour to a
// 4-bit palette index and writes it to frame RAM at base + y*SHEET_W + x.
module sprite_palette_encoder #(
    parameter int SHEET_W = 46,
    parameter int ADDR_W  = 20
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [9:0]        rect_w,
    input  logic [9:0]        rect_h,
    input  logic              pix_valid,
    input  logic [23:0]       pix_rgb,
    output logic              pix_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [3:0]        wr_data,
    output logic              busy,
    output logic              done,
    output logic              bad_color
);

    localparam int PW = ADDR_W + 32;

    typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] base_q;
    logic [9:0]        w_q, h_q, x_q, y_q;
    logic              accept, last_x, last_pix, start_ok, empty_rect;
    logic [4:0]        pal;
    logic [ADDR_W-1:0] addr_calc;

    // {hit, index}; a miss yields index 0 with hit clear
    function automatic logic [4:0] palette(input logic [23:0] rgb);
        case (rgb)
            24'h800080: return 5'h10;
            24'hFFFDFB: return 5'h11;
            24'hB53121: return 5'h12;
            24'hF83800: return 5'h13;
            24'hE18300: return 5'h14;
            24'h1D7B01: return 5'h15;
            24'hAC7C00: return 5'h16;
            24'hD4E7C7: return 5'h17;
            24'h057987: return 5'h18;
            24'h000000: return 5'h19;
            default:    return 5'h00;
        endcase
    endfunction

    assign accept     = pix_valid && pix_ready;
    assign last_x     = (x_q == w_q - 10'd1);
    assign last_pix   = last_x && (y_q == h_q - 10'd1);
    assign start_ok   = start && (state == IDLE);
    assign empty_rect = (rect_w == 10'd0) || (rect_h == 10'd0);
    assign pal        = palette(pix_rgb);

    // Product formed at full width, then wrapped to the RAM address space
    assign addr_calc = ADDR_W'(PW'(base_q) + PW'(y_q) * PW'(SHEET_W) + PW'(x_q));

    always_ff @(posedge Clk) begin
        if (Reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = empty_rect ? DONE : LOAD;
            LOAD:    if (accept && last_pix) state_nxt = DRAIN;
            DRAIN:   state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        pix_ready = (state == LOAD);
        busy      = (state == LOAD) || (state == DRAIN);
        done      = (state == DONE);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            base_q    <= '0;
            w_q       <= '0;
            h_q       <= '0;
            x_q       <= '0;
            y_q       <= '0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            bad_color <= 1'b0;
        end else begin
            wr_en <= accept;
            if (start_ok) begin
                base_q    <= base_addr;
                w_q       <= rect_w;
                h_q       <= rect_h;
                x_q       <= '0;
                y_q       <= '0;
                bad_color <= 1'b0;
            end
            if (accept) begin
                wr_addr <= addr_calc;
                wr_data <= pal[3:0];
                if (!pal[4]) bad_color <= 1'b1;
                if (last_x) begin
                    x_q <= '0;
                    y_q <= y_q + 10'd1;
                end else begin
                    x_q <= x_q + 10'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_sprite_palette_encoder.sv
// Directed bench for sprite_palette_encoder; expected writes go through a queue
// scoreboard tagged with the cycle they must appear in.
module tb_sprite_palette_encoder;

    logic        Clk = 1'b0;
    logic        Reset, start, pix_valid;
    logic [19:0] base_addr;
    logic [9:0]  rect_w, rect_h;
    logic [23:0] pix_rgb;
    logic        pix_ready, wr_en, busy, done, bad_color;
    logic [19:0] wr_addr;
    logic [3:0]  wr_data;

    typedef struct {
        int          cyc;
        logic [19:0] addr;
        logic [3:0]  data;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   wr_count = 0;
    int   n0;

    logic [23:0] pal_c [10] = '{24'h800080, 24'hFFFDFB, 24'hB53121, 24'hF83800, 24'hE18300,
                                24'h1D7B01, 24'hAC7C00, 24'hD4E7C7, 24'h057987, 24'h000000};

    sprite_palette_encoder #(.SHEET_W(46), .ADDR_W(20)) dut (
        .Clk(Clk), .Reset(Reset), .start(start), .base_addr(base_addr),
        .rect_w(rect_w), .rect_h(rect_h), .pix_valid(pix_valid), .pix_rgb(pix_rgb),
        .pix_ready(pix_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .done(done), .bad_color(bad_color)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Write-port monitor: every wr_en must match the oldest expected write and cycle
    always @(negedge Clk) begin
        exp_t e;
        if (sb.size() > 0 && sb[0].cyc < cyc) begin
            e = sb.pop_front();
            tests++;
            fails++;
            $error("FAIL missed_write: observed none expected addr %0h at cycle %0d", e.addr, e.cyc);
        end
        if (wr_en === 1'b1) begin
            wr_count++;
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $error("FAIL unexpected_write: observed addr %0h data %0h expected no write", wr_addr, wr_data);
            end else begin
                e = sb.pop_front();
                chk("wr_cycle", cyc, e.cyc);
                chk("wr_addr", {12'd0, wr_addr}, {12'd0, e.addr});
                chk("wr_data", {28'd0, wr_data}, {28'd0, e.data});
            end
        end
    end

    task automatic tick();
        @(posedge Clk);
        @(negedge Clk);
    endtask

    task automatic do_start(input logic [19:0] b, input logic [9:0] w, input logic [9:0] h);
        start = 1'b1; base_addr = b; rect_w = w; rect_h = h;
        tick();
        start = 1'b0;
    endtask

    task automatic pix(input logic [23:0] rgb, input logic [19:0] addr, input logic [3:0] idx);
        exp_t e;
        chk("pix_ready", {31'd0, pix_ready}, 32'd1);
        pix_valid = 1'b1;
        pix_rgb   = rgb;
        e.cyc = cyc + 1; e.addr = addr; e.data = idx;
        sb.push_back(e);
        tick();
        pix_valid = 1'b0;
    endtask

    task automatic fin();
        chk("ready_drop", {31'd0, pix_ready}, 32'd0);
        tick();
        chk("done_pulse", {31'd0, done}, 32'd1);
        chk("busy_at_done", {31'd0, busy}, 32'd0);
        tick();
        chk("done_off", {31'd0, done}, 32'd0);
    endtask

    initial begin
        Reset = 1'b1; start = 1'b0; pix_valid = 1'b0; pix_rgb = '0;
        base_addr = '0; rect_w = '0; rect_h = '0;
        @(negedge Clk);
        tick(); tick();
        chk("rst_ready", {31'd0, pix_ready}, 32'd0);
        chk("rst_wr_en", {31'd0, wr_en}, 32'd0);
        chk("rst_wr_addr", {12'd0, wr_addr}, 32'd0);
        chk("rst_wr_data", {28'd0, wr_data}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_bad", {31'd0, bad_color}, 32'd0);
        Reset = 1'b0;
        tick();

        // 2x2 at base 0, back-to-back
        do_start(20'd0, 10'd2, 10'd2);
        chk("busy_load", {31'd0, busy}, 32'd1);
        pix(24'h800080, 20'd0, 4'd0);
        pix(24'hFFFDFB, 20'd1, 4'd1);
        pix(24'hB53121, 20'd46, 4'd2);
        pix(24'h000000, 20'd47, 4'd9);
        chk("busy_drain", {31'd0, busy}, 32'd1);
        fin();
        chk("bad_clean", {31'd0, bad_color}, 32'd0);

        // 3x1 at 230 with valid gaps
        do_start(20'd230, 10'd3, 10'd1);
        pix(24'hF83800, 20'd230, 4'd3);
        tick();
        pix(24'hE18300, 20'd231, 4'd4);
        tick();
        pix(24'h1D7B01, 20'd232, 4'd5);
        fin();

        // Unknown colour sets bad_color; next start clears it
        do_start(20'd5, 10'd1, 10'd1);
        pix(24'h123456, 20'd5, 4'd0);
        fin();
        chk("bad_set", {31'd0, bad_color}, 32'd1);
        do_start(20'd0, 10'd1, 10'd1);
        chk("bad_cleared", {31'd0, bad_color}, 32'd0);
        pix(24'h057987, 20'd0, 4'd8);
        fin();

        // Zero-width rectangle: done without writes
        do_start(20'd7, 10'd0, 10'd3);
        chk("zero_done", {31'd0, done}, 32'd1);
        chk("zero_busy", {31'd0, busy}, 32'd0);
        tick();
        chk("zero_done_off", {31'd0, done}, 32'd0);

        // 4x4 with start held high during the load
        n0 = wr_count;
        do_start(20'd100, 10'd4, 10'd4);
        start = 1'b1; base_addr = 20'd1000; rect_w = 10'd1; rect_h = 10'd1;
        for (int i = 0; i < 16; i++) begin
            pix(pal_c[i % 10], 20'(100 + (i / 4) * 46 + (i % 4)), 4'(i % 10));
            if (i == 3) start = 1'b0;
        end
        fin();
        chk("wr_count16", wr_count - n0, 32'd16);

        // Reset after 5 of 16 pixels
        do_start(20'd0, 10'd4, 10'd4);
        for (int i = 0; i < 5; i++)
            pix(pal_c[i], 20'(i / 4 * 46 + i % 4), 4'(i));
        Reset = 1'b1; pix_valid = 1'b1; pix_rgb = 24'h800080;
        tick();
        Reset = 1'b0; pix_valid = 1'b0;
        chk("rst_mid_wr_en", {31'd0, wr_en}, 32'd0);
        chk("rst_mid_ready", {31'd0, pix_ready}, 32'd0);
        chk("rst_mid_busy", {31'd0, busy}, 32'd0);
        chk("rst_mid_done", {31'd0, done}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_no_done", {31'd0, done}, 32'd0);
        end

        // Address wrap at the top of the RAM
        do_start(20'hFFFFF, 10'd2, 10'd1);
        pix(24'hAC7C00, 20'hFFFFF, 4'd6);
        pix(24'hD4E7C7, 20'h00000, 4'd7);
        fin();

        tick(); tick();
        chk("sb_empty", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sprite_palette_encoder.md
SPRITE_PALETTE_ENCODER -- requirements
Module: sprite_palette_encoder

Interface
REQ-001 Parameter SHEET_W, default 46, SHALL be the sprite-sheet row pitch in pixels, used for address generation.
REQ-002 Parameter ADDR_W, default 20, SHALL be the frame-RAM address width.
REQ-003 Clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 Reset  input  1  SHALL be the synchronous, active-high reset.
REQ-005 start  input  1  SHALL be a one-cycle request to begin loading one rectangle.
REQ-006 base_addr  input  ADDR_W  SHALL be the RAM address of the rectangle's top-left pixel, sampled on the start cycle.
REQ-007 rect_w, rect_h  input  10 each  SHALL be the rectangle width and height in pixels, sampled on the start cycle.
REQ-008 pix_valid  input  1  SHALL mark pix_rgb as valid.
REQ-009 pix_rgb  input  24  SHALL carry the pixel colour as {R[7:0],G[7:0],B[7:0]}, in raster order.
REQ-010 pix_ready  output  1  SHALL indicate that the block accepts a pixel this cycle.
REQ-011 wr_en, wr_addr, wr_data  output  1 / ADDR_W / 4  SHALL form the frame-RAM write port: enable, address, palette index.
REQ-012 busy  output  1  SHALL be high from the cycle after an accepted start until done.
REQ-013 done  output  1  SHALL be a one-cycle completion pulse.
REQ-014 bad_color  output  1  SHALL be a sticky flag, set when a pixel colour matches no palette entry.

Function
REQ-015 States SHALL be IDLE, LOAD, DRAIN, DONE.
REQ-016 IDLE + start: SHALL latch base/w/h, clear x/y counters and bad_color, and go to LOAD. If rect_w==0 or rect_h==0, it SHALL go to DONE instead, with no writes.
REQ-017 start outside IDLE SHALL be ignored.
REQ-018 pix_ready SHALL equal 1 only in LOAD; a pixel is accepted when pix_valid && pix_ready.
REQ-019 Palette match, exact 24-bit compare: 800080->0, FFFDFB->1, B53121->2, F83800->3, E18300->4, 1D7B01->5, AC7C00->6, D4E7C7->7, 057987->8, 000000->9.
REQ-020 Unmatched colour SHALL write index 0 and set bad_color, which stays set until the next accepted start or Reset.
REQ-021 An accepted pixel in cycle N SHALL produce wr_en=1 in cycle N+1, with wr_addr = base_addr + y*SHEET_W + x (truncated mod 2^ADDR_W) and wr_data = index. x and y are the counters at acceptance.
REQ-022 wr_en SHALL be 0 in every cycle not following an acceptance; back-to-back acceptances SHALL give back-to-back writes (1 pixel/cycle).
REQ-023 Counter update on acceptance: x+1; when x==rect_w-1, x SHALL reset to 0 and y SHALL increment.
REQ-024 Acceptance with x==rect_w-1 and y==rect_h-1 SHALL move LOAD->DRAIN; pix_ready SHALL drop the next cycle.
REQ-025 DRAIN (the cycle of the last write) SHALL move to DONE; DONE SHALL pulse done=1 for one cycle, with busy=0, then return to IDLE.
REQ-026 pix_valid low in LOAD SHALL stall: no write and no counter change.
REQ-027 The y*SHEET_W product SHALL be computed at full width before truncation to ADDR_W.

Reset
REQ-028 Reset SHALL force, at the next edge: state IDLE, pix_ready=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0, bad_color=0, counters=0.
REQ-029 Reset mid-LOAD SHALL abandon the rectangle; no further writes SHALL occur and no done SHALL pulse.

Verification
REQ-030 start, base=0, w=2, h=2; pixels 800080, FFFDFB, B53121, 000000 back-to-back -> writes (0,0), (1,1), (46,2), (47,9) on consecutive cycles; done one cycle after the last write; bad_color=0.
REQ-031 base=230, w=3, h=1, pix_valid toggled 1,0,1,0,1 -> 3 writes to 230, 231, 232, each one cycle after its acceptance.
REQ-032 Pixel 123456 in a 1x1 load -> write data 0, bad_color=1; a subsequent start clears it.
REQ-033 start with w=0 -> no wr_en, done pulses; a second start while busy during a 4x4 load -> ignored, exactly 16 writes.
REQ-034 Reset asserted after 5 of 16 pixels -> wr_en=0 and pix_ready=0 the next cycle, no done pulse, busy=0.
REQ-035 base=FFFFF, w=2, h=1 -> second write address wraps to 00000.
